multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1: 1 = FSM waits on mem_ready; 0 = mem_ready treated as constant 1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-004 op  input  7  instr[6:0] from instruction register.
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  unified memory access complete this cycle.
REQ-009 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables/selects.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  mux selects.
REQ-011 ALUControl  output  3  ALU operation.
REQ-012 instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
REQ-013 illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-014 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ; outputs are Moore, except PCWrite, IRWrite and MEMREAD/MEMWRITE exits, which are gated by mem_ready/zero.
REQ-015 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10; IRWrite=PCUpdate=1 only when mem_ready=1; stays in FETCH while mem_ready=0, else goes to DECODE.
REQ-016 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add; next state by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1101111 -> JAL, 1100011 -> BEQ; any other op -> FETCH with illegal_op=1.
REQ-017 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add; lw -> MEMREAD, sw -> MEMWRITE.
REQ-018 MEMREAD: AdrSrc=1, ResultSrc=00; holds while mem_ready=0, else goes to MEMWB.
REQ-019 MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 -> FETCH.
REQ-020 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until mem_ready=1; then instr_done=1 -> FETCH.
REQ-021 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=func -> ALUWB. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=func -> ALUWB.
REQ-022 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCUpdate=1 -> ALUWB.
REQ-023 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 -> FETCH.
REQ-024 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1, instr_done=1 -> FETCH.
REQ-025 PCWrite = PCUpdate | (Branch & zero); every unlisted output is 0 in the state.
REQ-026 ALU decode (ALUControl): add -> 000; sub -> 001; func with funct3 000 -> 001 if {op[5],funct7b5}=11, else 000; 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
REQ-027 ImmSrc: lw/I-type 00, sw 01, beq 10, jal 11, all others 00; this decode is combinational from op in every state.
REQ-028 Instruction latency with mem_ready=1: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles; each memory wait cycle adds 1.

Reset
REQ-029 reset=0 immediately forces state=FETCH; while reset=0, PCWrite, IRWrite, RegWrite, MemWrite, instr_done and illegal_op are 0; mux selects take FETCH values.
REQ-030 Reset asserted mid-instruction (including during a MEMWRITE wait) aborts the instruction, with no further write enables; after release, the first cycle is FETCH.

Structure
REQ-031 Shared package riscv_ctrl_pkg holds the state encoding, opcode constants, the ALUOp enum (add/sub/func) and the ALUControl codes.
REQ-032 One combinational sub-module alu_decoder (ALUOp, funct3, op[5], funct7b5 -> ALUControl); the FSM and output decode stay in multicycle_controller.

Verification
REQ-033 Reset release, mem_ready=1, op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5; instr_done pulses once.
REQ-034 op=0100011, mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, then FETCH.
REQ-035 op=1100011 with zero=1 and then zero=0 -> PCWrite=1 in BEQ only when zero=1; ALUControl=001 in BEQ.
REQ-036 op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECR; op=0010011, funct3=000, funct7b5=1 -> ALUControl=000.
REQ-037 op=1111111 -> illegal_op=1 for one cycle in DECODE, next state FETCH, no write enables asserted.
REQ-038 reset=0 asserted mid-MEMREAD wait -> state=FETCH asynchronously, all enables 0; after release, a fetch with mem_ready=1 gives IRWrite=PCWrite=1.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V controller: state encoding,
// opcodes, ALU operation classes, ALUControl codes and the Moore output table.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'd0,
    ALUOP_SUB  = 2'd1,
    ALUOP_FUNC = 2'd2
  } aluop_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Unconditional per-state outputs; mem_ready/zero gated ones are built in the top.
  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       pc_update;
    logic       done;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    aluop_t     alu_op;
  } ctrl_t;

  function automatic ctrl_t moore_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = ALUOP_FUNC;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALUOP_FUNC;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = ALUOP_SUB;
        c.branch    = 1'b1;
        c.done      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class plus instruction fields to the ALUControl code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t     alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALUCTL_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALUCTL_ADD;
      ALUOP_SUB: alu_control_o = ALUCTL_SUB;
      ALUOP_FUNC: begin
        case (funct3_i)
          // Only R-type with funct7b5 set subtracts; addi never does.
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b010:  alu_control_o = ALUCTL_SLT;
          3'b110:  alu_control_o = ALUCTL_OR;
          3'b111:  alu_control_o = ALUCTL_AND;
          default: alu_control_o = ALUCTL_ADD;
        endcase
      end
      default: alu_control_o = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: registered Moore outputs, with PCWrite, IRWrite
// and the MEMWRITE completion gated combinationally by mem_ready and zero.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal_op,
  output state_t     dbg_state
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  logic   mem_rdy;
  logic   in_fetch;
  logic   legal_op;

  assign mem_rdy  = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign in_fetch = (state_q == S_FETCH);
  assign legal_op = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                    (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BEQ);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      // op[5] separates sw from lw.
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output register is loaded with the table entry of the state being entered,
  // so ctrl_q always matches state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= moore_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= moore_ctrl(state_d);
    end
  end

  // FETCH is also the reset state, so its gated enables must see reset directly.
  assign IRWrite    = reset & in_fetch & mem_rdy;
  assign PCWrite    = reset & ((in_fetch & mem_rdy) | ctrl_q.pc_update |
                               (ctrl_q.branch & zero));
  assign AdrSrc     = ctrl_q.adr_src;
  assign MemWrite   = ctrl_q.mem_write;
  assign RegWrite   = ctrl_q.reg_write;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign instr_done = ctrl_q.done | ((state_q == S_MEMWRITE) & mem_rdy);
  assign illegal_op = (state_q == S_DECODE) & ~legal_op;
  assign dbg_state  = state_q;

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (ctrl_q.alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: builds an expected per-cycle trace for each instruction
// from the state/latency tables and compares it with the controller outputs.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  // en = {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,instr_done,illegal_op}
  // sel = {ResultSrc,ALUSrcA,ALUSrcB}
  typedef struct packed {
    state_t     st;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       mr;
    logic       z;
    logic [6:0] en;
    logic [5:0] sel;
    logic       ca;
    logic [2:0] alu;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = OP_LW;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       instr_done, illegal_op;
  state_t     dbg_state;

  cyc_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  int         n_done, n_mw, n_mw_run, n_mw_max, n_beq_pcw, n_ill, n_wen;
  logic [2:0] last_exec_alu;

  multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .instr_done(instr_done), .illegal_op(illegal_op),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (o[5] && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  task automatic push(input state_t st, input logic mr, input logic z, input logic [6:0] en,
                      input logic [5:0] sel, input logic ca, input logic [2:0] alu);
    cyc_t c;
    c.st = st; c.op = cur_op; c.f3 = cur_f3; c.f7 = cur_f7; c.mr = mr; c.z = z;
    c.en = en; c.sel = sel; c.ca = ca; c.alu = alu;
    exp_q.push_back(c);
  endtask

  // Expected trace of one instruction: wf fetch waits, wm memory-stage waits.
  task automatic add_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic bz, input int wf, input int wm);
    cur_op = o; cur_f3 = f3; cur_f7 = f7;
    for (int i = 0; i < wf; i++) push(S_FETCH, 1'b0, rb(), 7'b0000000, 6'b100010, 1'b1, 3'b000);
    push(S_FETCH, 1'b1, rb(), 7'b1001000, 6'b100010, 1'b1, 3'b000);
    case (o)
      OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ:
        push(S_DECODE, rb(), rb(), 7'b0000000, 6'b000101, 1'b1, 3'b000);
      default: begin
        push(S_DECODE, rb(), rb(), 7'b0000001, 6'b000101, 1'b1, 3'b000);
        return;
      end
    endcase
    case (o)
      OP_LW: begin
        push(S_MEMADR, rb(), rb(), 7'b0000000, 6'b001001, 1'b1, 3'b000);
        for (int i = 0; i < wm; i++) push(S_MEMREAD, 1'b0, rb(), 7'b0100000, 6'b000000, 1'b0, 3'b000);
        push(S_MEMREAD, 1'b1, rb(), 7'b0100000, 6'b000000, 1'b0, 3'b000);
        push(S_MEMWB, rb(), rb(), 7'b0000110, 6'b010000, 1'b0, 3'b000);
      end
      OP_SW: begin
        push(S_MEMADR, rb(), rb(), 7'b0000000, 6'b001001, 1'b1, 3'b000);
        for (int i = 0; i < wm; i++) push(S_MEMWRITE, 1'b0, rb(), 7'b0110000, 6'b000000, 1'b0, 3'b000);
        push(S_MEMWRITE, 1'b1, rb(), 7'b0110010, 6'b000000, 1'b0, 3'b000);
      end
      OP_RTYPE, OP_ITYPE: begin
        push((o == OP_RTYPE) ? S_EXECR : S_EXECI, rb(), rb(), 7'b0000000,
             (o == OP_RTYPE) ? 6'b001000 : 6'b001001, 1'b1, ref_alu(o, f3, f7));
        push(S_ALUWB, rb(), rb(), 7'b0000110, 6'b000000, 1'b0, 3'b000);
      end
      OP_JAL: begin
        push(S_JAL, rb(), rb(), 7'b1000000, 6'b000110, 1'b1, 3'b000);
        push(S_ALUWB, rb(), rb(), 7'b0000110, 6'b000000, 1'b0, 3'b000);
      end
      default: push(S_BEQ, rb(), bz, {bz, 6'b000010}, 6'b001000, 1'b1, 3'b001);
    endcase
  endtask

  task automatic clear_counts();
    n_done = 0; n_mw = 0; n_mw_run = 0; n_mw_max = 0; n_beq_pcw = 0; n_ill = 0; n_wen = 0;
  endtask

  // Scoreboard: pops n expected cycles (n<0: all), entered and left just after a negedge.
  task automatic drain(input int n);
    cyc_t c;
    while (exp_q.size() > 0 && n != 0) begin
      c = exp_q.pop_front();
      if (n > 0) n--;
      op = c.op; funct3 = c.f3; funct7b5 = c.f7; mem_ready = c.mr; zero = c.z;
      #1;
      total++;
      if (dbg_state !== c.st) begin
        bad++; $display("FAIL state cyc%0d got %0d want %0d", cyc, dbg_state, c.st);
      end
      total++;
      if ({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op} !== c.en) begin
        bad++;
        $display("FAIL enables cyc%0d got %b want %b", cyc,
                 {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op}, c.en);
      end
      total++;
      if ({ResultSrc, ALUSrcA, ALUSrcB} !== c.sel) begin
        bad++; $display("FAIL selects cyc%0d got %b want %b", cyc, {ResultSrc, ALUSrcA, ALUSrcB}, c.sel);
      end
      total++;
      if (ImmSrc !== ref_imm(c.op)) begin
        bad++; $display("FAIL immsrc cyc%0d got %b want %b", cyc, ImmSrc, ref_imm(c.op));
      end
      if (c.ca) begin
        total++;
        if (ALUControl !== c.alu) begin
          bad++; $display("FAIL aluctl cyc%0d got %b want %b", cyc, ALUControl, c.alu);
        end
      end
      if (c.st == S_EXECR || c.st == S_EXECI) last_exec_alu = ALUControl;
      if (c.st == S_BEQ && PCWrite === 1'b1) n_beq_pcw++;
      if (instr_done === 1'b1) n_done++;
      if (illegal_op === 1'b1) n_ill++;
      if (RegWrite === 1'b1 || MemWrite === 1'b1) n_wen++;
      if (MemWrite === 1'b1) begin
        n_mw++; n_mw_run++;
        if (n_mw_run > n_mw_max) n_mw_max = n_mw_run;
      end else n_mw_run = 0;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; op = OP_LW; mem_ready = 1'b1; zero = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (dbg_state !== S_FETCH) begin bad++; $display("FAIL reset_state got %0d want %0d", dbg_state, S_FETCH); end
    total++;
    if ({PCWrite, MemWrite, IRWrite, RegWrite, instr_done, illegal_op} !== 6'b0) begin
      bad++; $display("FAIL reset_enables got %b want 000000",
                      {PCWrite, MemWrite, IRWrite, RegWrite, instr_done, illegal_op});
    end
    total++;
    if ({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl} !== 10'b0_10_00_10_000) begin
      bad++; $display("FAIL reset_selects got %b want 0100010000",
                      {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_lw();
    clear_counts();
    add_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 0);
    total++;
    if (exp_q.size() != 5) begin bad++; $display("FAIL lw_latency got %0d want 5", exp_q.size()); end
    drain(-1);
    total++;
    if (n_done != 1) begin bad++; $display("FAIL lw_done_pulses got %0d want 1", n_done); end
  endtask

  task automatic test_sw_wait();
    clear_counts();
    add_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 3);
    drain(-1);
    total++;
    if (n_mw != 4 || n_mw_max != 4) begin
      bad++; $display("FAIL sw_memwrite_run got %0d/%0d want 4/4", n_mw, n_mw_max);
    end
  endtask

  task automatic test_beq();
    clear_counts();
    add_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
    add_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 1, 0);
    drain(-1);
    total++;
    if (n_beq_pcw != 1) begin bad++; $display("FAIL beq_pcwrite got %0d want 1", n_beq_pcw); end
  endtask

  task automatic test_alu();
    add_instr(OP_RTYPE, 3'b000, 1'b1, 1'b0, 0, 0);
    drain(-1);
    total++;
    if (last_exec_alu !== 3'b001) begin bad++; $display("FAIL sub_aluctl got %b want 001", last_exec_alu); end
    add_instr(OP_ITYPE, 3'b000, 1'b1, 1'b0, 0, 0);
    drain(-1);
    total++;
    if (last_exec_alu !== 3'b000) begin bad++; $display("FAIL addi_aluctl got %b want 000", last_exec_alu); end
  endtask

  task automatic test_illegal();
    clear_counts();
    add_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
    add_instr(OP_RTYPE, 3'b110, 1'b0, 1'b0, 0, 0);
    drain(-1);
    total++;
    if (n_ill != 1) begin bad++; $display("FAIL illegal_pulses got %0d want 1", n_ill); end
  endtask

  task automatic test_reset_midread();
    add_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 6);
    drain(4);
    exp_q.delete();
    mem_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++;
    if (dbg_state !== S_FETCH) begin bad++; $display("FAIL async_reset_state got %0d want %0d", dbg_state, S_FETCH); end
    mem_ready = 1'b1;
    #1;
    total++;
    if ({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done} !== 6'b0) begin
      bad++; $display("FAIL async_reset_enables got %b want 000000",
                      {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done});
    end
    @(negedge clk);
    reset = 1'b1;
    add_instr(OP_RTYPE, 3'b111, 1'b0, 1'b0, 0, 0);
    drain(-1);
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_RTYPE; ops[3] = OP_ITYPE;
    ops[4] = OP_JAL; ops[5] = OP_BEQ; ops[6] = 7'b0;
    for (int i = 0; i < 80; i++) begin
      int k;
      logic [6:0] o;
      k = $urandom_range(0, 6);
      o = (k == 6) ? 7'($urandom) : ops[k];
      add_instr(o, 3'($urandom), rb(), rb(), $urandom_range(0, 3), $urandom_range(0, 3));
      drain(-1);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_alu();
    test_illegal();
    test_reset_midread();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
